// File: rtl/drive_cmd_framer.sv
// drive_cmd_framer: turns the 3-bit drive command stream into ASCII frames '$', char, [csum], '\n'.
// Define DRIVE_CMD_FRAMER_CHECKSUM_EN to build the checksum byte (4-byte frames).
module drive_cmd_framer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int HEARTBEAT_MS = 100,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] command,
    input  logic       valid,
    input  logic       uart_ready,
    output logic [7:0] ascii_out,
    output logic       cmd_ready,
    output logic       overflow
);
    localparam int HB_CYCLES = CLK_HZ / 1000 * HEARTBEAT_MS;
    localparam int HBW       = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam logic [HBW-1:0] HB_LAST = HBW'(HB_CYCLES - 1);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        CMD,
`ifdef DRIVE_CMD_FRAMER_CHECKSUM_EN
        CSUM,
`endif
        EOF,
        GAP
    } state_t;

    function automatic logic [7:0] char_of(input logic [2:0] c);
        case (c)
            3'd0:    char_of = 8'h53;
            3'd1:    char_of = 8'h46;
            3'd2:    char_of = 8'h42;
            3'd3:    char_of = 8'h4C;
            3'd4:    char_of = 8'h52;
            3'd5:    char_of = 8'h6C;
            3'd6:    char_of = 8'h72;
            default: char_of = 8'h58;
        endcase
    endfunction

    logic [2:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [AW:0]    count;
    logic [2:0]     last_cmd, cur_cmd, wr_data;
    logic [7:0]     cur_char;
    logic [HBW-1:0] hb_cnt;
    state_t         state, after_gap;
    logic fifo_empty, fifo_full, pop, req, estop, push_ok, drop;
    logic hb_hit, hb_push, wr_en, xfer;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = (state == IDLE) && !fifo_empty;
    assign req        = valid && (command != last_cmd);
    assign estop      = req && (command == 3'd7);
    // A full FIFO still accepts a push when the same edge pops an entry.
    assign push_ok    = req && !estop && (!fifo_full || pop);
    assign drop       = req && !estop && fifo_full && !pop;
    assign hb_hit     = (hb_cnt == HB_LAST);
    assign hb_push    = hb_hit && fifo_empty && (state == IDLE) && !estop && !push_ok;
    assign wr_en      = push_ok || hb_push;
    assign wr_data    = push_ok ? command : last_cmd;
    assign xfer       = cmd_ready && uart_ready;
    assign cur_char   = char_of(cur_cmd);

    always_ff @(posedge clk) begin
        if (estop)
            mem[0] <= 3'd7;
        else if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (estop) begin
            // Emergency stop replaces the whole queue with itself.
            rd_ptr <= '0;
            wr_ptr <= AW'(1);
            count  <= (AW+1)'(1);
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_cmd <= 3'd0;
            hb_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (estop)        last_cmd <= 3'd7;
            else if (push_ok) last_cmd <= command;
            if (((state == SOF) && xfer) || hb_push) hb_cnt <= '0;
            else if (!hb_hit)                       hb_cnt <= hb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            after_gap <= IDLE;
            cur_cmd   <= 3'd0;
            ascii_out <= 8'h00;
            cmd_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    cur_cmd   <= mem[rd_ptr];
                    ascii_out <= 8'h24;
                    cmd_ready <= 1'b1;
                    state     <= SOF;
                end
                SOF: if (xfer) begin
                    cmd_ready <= 1'b0;
                    after_gap <= CMD;
                    state     <= GAP;
                end
                CMD: if (xfer) begin
                    cmd_ready <= 1'b0;
`ifdef DRIVE_CMD_FRAMER_CHECKSUM_EN
                    after_gap <= CSUM;
`else
                    after_gap <= EOF;
`endif
                    state     <= GAP;
                end
`ifdef DRIVE_CMD_FRAMER_CHECKSUM_EN
                CSUM: if (xfer) begin
                    cmd_ready <= 1'b0;
                    after_gap <= EOF;
                    state     <= GAP;
                end
`endif
                EOF: if (xfer) begin
                    cmd_ready <= 1'b0;
                    after_gap <= IDLE;
                    state     <= GAP;
                end
                GAP: begin
                    state <= after_gap;
                    case (after_gap)
                        CMD: begin
                            ascii_out <= cur_char;
                            cmd_ready <= 1'b1;
                        end
`ifdef DRIVE_CMD_FRAMER_CHECKSUM_EN
                        CSUM: begin
                            ascii_out <= {1'b0, cur_char[6:0] ^ 7'h24};
                            cmd_ready <= 1'b1;
                        end
`endif
                        EOF: begin
                            ascii_out <= 8'h0A;
                            cmd_ready <= 1'b1;
                        end
                        default: cmd_ready <= 1'b0;
                    endcase
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_drive_cmd_framer.sv
// Bench for drive_cmd_framer: directed scenarios pinned by hand plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_drive_cmd_framer;
    localparam int DEPTH = 4;
    localparam int HB    = 100;  // 100_000 Hz * 1 ms
`ifdef DRIVE_CMD_FRAMER_CHECKSUM_EN
    localparam int FL = 4;
`else
    localparam int FL = 3;
`endif
    // Push at count HB-1, one edge to pop into SOF, one edge to transfer.
    localparam int HB_PERIOD = 102;

    logic       clk = 0, reset = 1, valid = 0, uart_ready = 0;
    logic [2:0] command = 0;
    logic [7:0] ascii_out;
    logic       cmd_ready, overflow;

    int checks = 0, errors = 0, cyc = 0, ovf_cnt = 0;
    logic [7:0] seen[$];
    int         sof_t[$];

    drive_cmd_framer #(.CLK_HZ(100_000), .HEARTBEAT_MS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .command(command), .valid(valid), .uart_ready(uart_ready),
        .ascii_out(ascii_out), .cmd_ready(cmd_ready), .overflow(overflow));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Reference model: pending commands and current frame bytes kept as plain queues.
    string      cmap = "SFBLRlrX";
    int         mq[$];
    logic [7:0] tx[$];
    bit         busy, gap, m_rdy, m_ovf, m_sof, m_xfer, m_idle, m_empty, m_pop, m_acc, m_fire;
    logic [7:0] m_byte, c;
    logic [2:0] m_last;
    int         hb, head;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete(); tx.delete();
            busy = 0; gap = 0; m_rdy = 0; m_ovf = 0; m_sof = 0;
            m_byte = 0; m_last = 0; hb = 0;
        end else begin
            m_xfer  = m_rdy && uart_ready;
            m_idle  = !busy;
            m_empty = (mq.size() == 0);
            m_pop   = m_idle && !m_empty;
            head    = m_pop ? mq.pop_front() : 0;
            m_acc   = 0;
            m_ovf   = 0;
            if (valid && command != m_last) begin
                if (command == 3'd7) begin
                    mq.delete(); mq.push_back(7); m_last = 7; m_acc = 1;
                end else if (mq.size() < DEPTH) begin
                    mq.push_back(int'(command)); m_last = command; m_acc = 1;
                end else
                    m_ovf = 1;
            end
            m_fire = (hb == HB - 1) && m_empty && m_idle && !m_acc;
            if (m_fire) mq.push_back(int'(m_last));
            if ((m_xfer && m_sof) || m_fire) hb = 0;
            else if (hb < HB - 1) hb++;
            if (m_xfer) begin
                void'(tx.pop_front());
                m_rdy = 0; m_sof = 0; gap = 1;
            end else if (gap) begin
                gap = 0;
                if (tx.size() > 0) begin m_byte = tx[0]; m_rdy = 1; end
                else busy = 0;
            end else if (m_pop) begin
                c = cmap[head];
                tx.push_back(8'h24);
                tx.push_back(c);
`ifdef DRIVE_CMD_FRAMER_CHECKSUM_EN
                tx.push_back((c ^ 8'h24) & 8'h7F);
`endif
                tx.push_back(8'h0A);
                busy = 1; m_byte = tx[0]; m_rdy = 1; m_sof = 1;
            end
        end
    end

    // Per-cycle compare and transfer log, away from the active edge.
    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, m_rdy);
        chk("overflow", overflow, m_ovf);
        if (m_rdy) chk("ascii_out", ascii_out, m_byte);
        if (!reset) begin
            if (cmd_ready && uart_ready) begin
                seen.push_back(ascii_out);
                if (ascii_out == 8'h24) sof_t.push_back(cyc);
            end
            if (overflow) ovf_cnt++;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; valid = 0;
        step(); step();
        reset = 0;
        seen.delete(); sof_t.delete(); ovf_cnt = 0;
    endtask

    task automatic send(input logic [2:0] cmd);
        command = cmd; valid = 1; step(); valid = 0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k = 0;
        while (seen.size() < n && k < budget) begin step(); k++; end
        chk(name, seen.size() >= n, 1);
    endtask

    initial begin
        #12;
        chk("rst_ascii", ascii_out, 8'h00);
        chk("rst_rdy", cmd_ready, 0);
        chk("rst_ovf", overflow, 0);

        // 1: single command, latency and byte content
        do_reset(); uart_ready = 1;
        send(3'd1);
        chk("lat_early", cmd_ready, 0);
        step();
        chk("lat_rdy", cmd_ready, 1);
        chk("lat_sof", ascii_out, 8'h24);
        wait_bytes(FL, 40, "t1_timeout");
        if (seen.size() >= FL) begin
            chk("t1_b0", seen[0], 8'h24);
            chk("t1_b1", seen[1], 8'h46);
`ifdef DRIVE_CMD_FRAMER_CHECKSUM_EN
            chk("t1_b2", seen[2], 8'h62);
`endif
            chk("t1_eof", seen[FL-1], 8'h0A);
        end

        // 2: held command gives one frame only
        do_reset(); uart_ready = 1;
        command = 3'd2; valid = 1;
        repeat (80) step();
        valid = 0;
        chk("t2_one_frame", seen.size(), FL);

        // 3: heartbeat resends 'R'
        do_reset(); uart_ready = 1;
        send(3'd4);
        repeat (330) step();
        chk("t3_sofs", sof_t.size() >= 3, 1);
        if (sof_t.size() >= 3) begin
            chk("t3_period0", sof_t[1] - sof_t[0], HB_PERIOD);
            chk("t3_period1", sof_t[2] - sof_t[1], HB_PERIOD);
            chk("t3_char", seen[2*FL+1], 8'h52);
        end

        // 4: overflow. 1 moves straight into the stalled frame, 2..5 fill the queue, 6 drops.
        do_reset(); uart_ready = 0;
        for (int i = 1; i <= 6; i++) begin command = 3'(i); valid = 1; step(); end
        valid = 0; step();
        chk("t4_ovf_once", ovf_cnt, 1);
        uart_ready = 1;
        wait_bytes(5*FL, 90, "t4_timeout");
        if (seen.size() >= 5*FL) begin
            chk("t4_c0", seen[1], 8'h46);
            chk("t4_c1", seen[FL+1], 8'h42);
            chk("t4_c2", seen[2*FL+1], 8'h4C);
            chk("t4_c3", seen[3*FL+1], 8'h52);
            chk("t4_c4", seen[4*FL+1], 8'h6C);
        end

        // 5: estop flushes the queue; the stalled 'F' frame completes, then only 'X'
        do_reset(); uart_ready = 0;
        for (int i = 1; i <= 3; i++) begin command = 3'(i); valid = 1; step(); end
        send(3'd7);
        step();
        chk("t5_no_ovf", ovf_cnt, 0);
        uart_ready = 1;
        wait_bytes(2*FL, 40, "t5_timeout");
        repeat (20) step();
        chk("t5_count", seen.size(), 2*FL);
        if (seen.size() >= 2*FL) begin
            chk("t5_c0", seen[1], 8'h46);
            chk("t5_c1", seen[FL+1], 8'h58);
        end

        // 6: asynchronous reset during the CMD byte
        do_reset(); uart_ready = 1;
        send(3'd2);
        begin
            int k = 0;
            while (!(cmd_ready && ascii_out == 8'h42) && k < 20) begin step(); k++; end
            chk("t6_reach_cmd", k < 20, 1);
        end
        #3 reset = 1;
        #1;
        chk("t6_rdy", cmd_ready, 0);
        chk("t6_ascii", ascii_out, 8'h00);
        step(); step(); reset = 0;
        seen.delete();
        repeat (60) step();
        chk("t6_quiet", seen.size(), 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            uart_ready = ($urandom_range(0, 3) != 0);
            valid      = ($urandom_range(0, 3) == 0);
            command    = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            step();
        end
        valid = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
